// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state/size encodings and lane formatting helpers for dmem_latency
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;
  function automatic logic is_misaligned(size_t sz, logic [1:0] lo);
    return (sz == SZ_HALF && lo[0]) || (sz == SZ_WORD && lo != 2'b00);
  endfunction
  // raw[31:24] is the byte at the effective address, raw[7:0] the byte at +3
  function automatic logic [31:0] fmt_read(size_t sz, logic sext, logic [31:0] raw);
    return sz == SZ_BYTE ? {{24{sext & raw[31]}}, raw[31:24]} :
           sz == SZ_HALF ? {{16{sext & raw[31]}}, raw[31:16]} : raw;
  endfunction
endpackage

// File: rtl/dmem_latency_if.sv
// dmem_latency_if: request/response bus of the latency data memory
interface dmem_latency_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic [0:ADDR_W-1] addr;
  logic              write_enable;
  logic              mem_byte;
  logic              mem_half_word;
  logic              sign_extend;
  logic [0:31]       data_in;
  logic              resp_valid;
  logic [0:31]       data_out;
  logic              misaligned;
  modport master(output req_valid, addr, write_enable, mem_byte, mem_half_word, sign_extend, data_in,
                 input req_ready, resp_valid, data_out, misaligned);
  modport slave(input req_valid, addr, write_enable, mem_byte, mem_half_word, sign_extend, data_in,
                output req_ready, resp_valid, data_out, misaligned);
endinterface

// File: rtl/dmem_align_fmt.sv
// dmem_align_fmt: big-endian lane selection, read extension and alignment check
module dmem_align_fmt
  import dmem_pkg::*;
(
  input  size_t       size_i,
  input  logic        sext_i,
  input  logic [1:0]  lo_i,
  input  logic [31:0] raw_i,
  input  logic [31:0] wdata_i,
  output logic        mis_o,
  output logic [31:0] rdata_o,
  output logic [31:0] wbytes_o,
  output logic [3:0]  wen_o
);
  // lane k of wbytes_o/wen_o (counting from the MSB) targets address a+k
  always_comb begin
    mis_o    = is_misaligned(size_i, lo_i);
    rdata_o  = mis_o ? '0 : fmt_read(size_i, sext_i, raw_i);
    wbytes_o = size_i == SZ_BYTE ? {wdata_i[7:0], 24'h0} :
               size_i == SZ_HALF ? {wdata_i[15:0], 16'h0} : wdata_i;
    wen_o    = mis_o ? 4'b0000 :
               size_i == SZ_BYTE ? 4'b1000 :
               size_i == SZ_HALF ? 4'b1100 : 4'b1111;
  end
endmodule

// File: rtl/dmem_latency.sv
// dmem_latency: byte-addressable big-endian data memory with valid/ready request and wait states
module dmem_latency
  import dmem_pkg::*;
#(
  parameter int SIZE    = 16384,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32
) (
  input  logic           clock,
  input  logic           reset,
  dmem_latency_if.slave  bus
);
  localparam int AW = $clog2(SIZE);
  localparam logic [3:0] LAT = 4'(LATENCY);
  logic [7:0] mem [0:SIZE-1];
  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] addr_q;
  size_t         size_q;
  logic          sext_q, we_q;
  logic [31:0]   wdata_q;
  logic          resp_valid_q, misaligned_q;
  logic [31:0]   data_out_q;
  logic [AW-1:0] addr_in, a;
  size_t         size_in, sz;
  logic          sx, we, accept, do_acc, mis;
  logic [31:0]   wd, raw, rdata, wbytes;
  logic [3:0]    wen;
  assign addr_in = bus.addr[ADDR_W-AW:ADDR_W-1];
  assign size_in = bus.mem_byte ? SZ_BYTE : bus.mem_half_word ? SZ_HALF : SZ_WORD;
  assign bus.req_ready  = state_q != WAIT;
  assign bus.resp_valid = resp_valid_q;
  assign bus.data_out   = data_out_q;
  assign bus.misaligned = misaligned_q;
  assign accept = bus.req_valid && bus.req_ready;
  assign do_acc = !reset && ((accept && LATENCY == 0) || (state_q == WAIT && cnt_q == 4'd1));
  // with zero latency the access happens on the accepting edge, straight from the bus
  assign a  = LATENCY == 0 ? addr_in : addr_q;
  assign sz = LATENCY == 0 ? size_in : size_q;
  assign sx = LATENCY == 0 ? bus.sign_extend : sext_q;
  assign we = LATENCY == 0 ? bus.write_enable : we_q;
  assign wd = LATENCY == 0 ? bus.data_in : wdata_q;
  assign raw = {mem[a], mem[a + AW'(1)], mem[a + AW'(2)], mem[a + AW'(3)]};
  dmem_align_fmt u_fmt (
    .size_i  (sz),
    .sext_i  (sx),
    .lo_i    (a[1:0]),
    .raw_i   (raw),
    .wdata_i (wd),
    .mis_o   (mis),
    .rdata_o (rdata),
    .wbytes_o(wbytes),
    .wen_o   (wen)
  );
  always_ff @(posedge clock)
    if (do_acc && we)
      for (int k = 0; k < 4; k++)
        if (wen[3-k]) mem[a + AW'(k)] <= wbytes[31-8*k -: 8];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      size_q       <= SZ_WORD;
      sext_q       <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      data_out_q   <= '0;
      misaligned_q <= 1'b0;
    end else begin
      resp_valid_q <= do_acc;
      if (do_acc) begin
        data_out_q   <= (we || mis) ? '0 : rdata;
        misaligned_q <= mis;
      end
      if (accept) begin
        addr_q  <= addr_in;
        size_q  <= size_in;
        sext_q  <= bus.sign_extend;
        we_q    <= bus.write_enable;
        wdata_q <= bus.data_in;
        cnt_q   <= LAT;
      end else if (state_q == WAIT)
        cnt_q <= cnt_q - 4'd1;
      state_q <= accept ? (LATENCY == 0 ? RESP : WAIT) :
                 state_q == WAIT ? (cnt_q == 4'd1 ? RESP : WAIT) : IDLE;
    end
endmodule

// File: tb/tb_dmem_latency.sv
// tb_dmem_latency: scoreboard bench for dmem_latency at LATENCY=2 and LATENCY=0
module tb_dmem_latency;
  typedef struct {
    logic [31:0] d;
    logic        m;
    int          c;
  } exp_t;
  logic clk = 1'b0;
  logic rst2 = 1'b0;
  logic rst0 = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q2[$];
  exp_t q0[$];
  exp_t e2, e0;
  dmem_latency_if #(.ADDR_W(32)) b2();
  dmem_latency_if #(.ADDR_W(32)) b0();
  dmem_latency #(.SIZE(16384), .LATENCY(2), .ADDR_W(32)) dut2 (.clock(clk), .reset(rst2), .bus(b2));
  dmem_latency #(.SIZE(16384), .LATENCY(0), .ADDR_W(32)) dut0 (.clock(clk), .reset(rst0), .bus(b0));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  always @(negedge clk)
    if (b2.resp_valid === 1'b1) begin
      if (q2.size() == 0) check("unexpected_resp2", 32'd1, 32'd0);
      else begin
        e2 = q2.pop_front();
        check("data2", b2.data_out, e2.d);
        check("mis2", {31'b0, b2.misaligned}, {31'b0, e2.m});
        check("lat2", cyc, e2.c);
      end
    end
  always @(negedge clk)
    if (b0.resp_valid === 1'b1) begin
      if (q0.size() == 0) check("unexpected_resp0", 32'd1, 32'd0);
      else begin
        e0 = q0.pop_front();
        check("data0", b0.data_out, e0.d);
        check("mis0", {31'b0, b0.misaligned}, {31'b0, e0.m});
        check("lat0", cyc, e0.c);
      end
    end
  // holds the request high through WAIT with corrupted fields to show they are ignored
  task automatic req2(input logic [31:0] a, input logic we, bt, hw, sx, input logic [31:0] d, ed, input logic em);
    int n = 0;
    @(negedge clk);
    b2.req_valid = 1'b1; b2.addr = a; b2.write_enable = we; b2.mem_byte = bt;
    b2.mem_half_word = hw; b2.sign_extend = sx; b2.data_in = d;
    while (b2.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("ready2", {31'b0, b2.req_ready}, 32'd1);
    q2.push_back('{ed, em, cyc + 3});
    repeat (2) begin
      @(negedge clk);
      b2.data_in = ~d; b2.addr = a ^ 32'h4; b2.write_enable = ~we;
      check("wait_ready2", {31'b0, b2.req_ready}, 32'd0);
    end
    @(negedge clk);
    b2.req_valid = 1'b0;
  endtask
  task automatic req0(input logic [31:0] a, input logic we, input logic [31:0] d, ed);
    @(negedge clk);
    b0.req_valid = 1'b1; b0.addr = a; b0.write_enable = we; b0.mem_byte = 1'b0;
    b0.mem_half_word = 1'b0; b0.sign_extend = 1'b0; b0.data_in = d;
    check("ready0", {31'b0, b0.req_ready}, 32'd1);
    q0.push_back('{ed, 1'b0, cyc + 1});
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    b2.req_valid = 0; b2.addr = 0; b2.write_enable = 0; b2.mem_byte = 0;
    b2.mem_half_word = 0; b2.sign_extend = 0; b2.data_in = 0;
    b0.req_valid = 0; b0.addr = 0; b0.write_enable = 0; b0.mem_byte = 0;
    b0.mem_half_word = 0; b0.sign_extend = 0; b0.data_in = 0;
    #2 rst2 = 1'b1; rst0 = 1'b1;
    repeat (2) @(negedge clk);
    rst2 = 1'b0; rst0 = 1'b0;
    @(negedge clk);
    check("rst_ready2", {31'b0, b2.req_ready}, 32'd1);
    check("rst_valid2", {31'b0, b2.resp_valid}, 32'd0);
    check("rst_data2", b2.data_out, 32'h0);
    check("rst_mis2", {31'b0, b2.misaligned}, 32'd0);
    check("rst_ready0", {31'b0, b0.req_ready}, 32'd1);
    req2(32'h2000, 1, 0, 0, 0, 32'hDEADBEEF, 32'h0, 0);
    check("mem2000", {24'b0, dut2.mem[32'h2000]}, 32'hDE);
    check("mem2003", {24'b0, dut2.mem[32'h2003]}, 32'hEF);
    req2(32'h2000, 0, 0, 0, 0, 32'h0, 32'hDEADBEEF, 0);
    req2(32'h2001, 1, 1, 0, 0, 32'h00000080, 32'h0, 0);
    req2(32'h2001, 0, 1, 0, 1, 32'h0, 32'hFFFFFF80, 0);
    req2(32'h2001, 0, 1, 0, 0, 32'h0, 32'h00000080, 0);
    req2(32'h2000, 0, 0, 1, 0, 32'h0, 32'h0000DE80, 0);
    req2(32'h2000, 0, 0, 1, 1, 32'h0, 32'hFFFFDE80, 0);
    req2(32'h2003, 0, 1, 1, 1, 32'h0, 32'hFFFFFFEF, 0);
    req2(32'h2004, 1, 0, 0, 0, 32'hCAFEF00D, 32'h0, 0);
    req2(32'h2002, 1, 0, 0, 0, 32'h12345678, 32'h0, 1);
    check("mis_mem2002", {24'b0, dut2.mem[32'h2002]}, 32'hBE);
    check("mis_mem2003", {24'b0, dut2.mem[32'h2003]}, 32'hEF);
    check("mis_mem2004", {24'b0, dut2.mem[32'h2004]}, 32'hCA);
    check("mis_mem2005", {24'b0, dut2.mem[32'h2005]}, 32'hFE);
    req2(32'h2001, 0, 0, 1, 0, 32'h0, 32'h0, 1);
    req2(32'h2004, 0, 0, 0, 0, 32'h0, 32'hCAFEF00D, 0);
    req2(32'h4010, 1, 0, 0, 0, 32'h0BADF00D, 32'h0, 0);
    check("wrap_mem10", {24'b0, dut2.mem[32'h10]}, 32'h0B);
    check("wrap_mem13", {24'b0, dut2.mem[32'h13]}, 32'h0D);
    req2(32'h0010, 0, 0, 0, 0, 32'h0, 32'h0BADF00D, 0);
    req2(32'h3000, 1, 0, 0, 0, 32'h01020304, 32'h0, 0);
    req2(32'h3000, 0, 0, 0, 0, 32'h0, 32'h01020304, 0);
    @(negedge clk);
    check("hold_data2", b2.data_out, 32'h01020304);
    b2.req_valid = 1'b1; b2.addr = 32'h3000; b2.write_enable = 1'b1; b2.mem_byte = 1'b0;
    b2.mem_half_word = 1'b0; b2.sign_extend = 1'b0; b2.data_in = 32'hA5A5A5A5;
    @(negedge clk);
    check("pend_ready2", {31'b0, b2.req_ready}, 32'd0);
    b2.req_valid = 1'b0;
    rst2 = 1'b1;
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mem3000", {24'b0, dut2.mem[32'h3000]}, 32'h01);
    check("rst_mem3001", {24'b0, dut2.mem[32'h3001]}, 32'h02);
    check("rst_mem3002", {24'b0, dut2.mem[32'h3002]}, 32'h03);
    check("rst_mem3003", {24'b0, dut2.mem[32'h3003]}, 32'h04);
    check("post_rst_ready2", {31'b0, b2.req_ready}, 32'd1);
    check("post_rst_data2", b2.data_out, 32'h0);
    req0(32'h2000, 1, 32'h11223344, 32'h0);
    req0(32'h2004, 1, 32'h55667788, 32'h0);
    req0(32'h2008, 1, 32'h99AABBCC, 32'h0);
    req0(32'h2000, 0, 32'h0, 32'h11223344);
    req0(32'h2004, 0, 32'h0, 32'h55667788);
    req0(32'h2008, 0, 32'h0, 32'h99AABBCC);
    @(negedge clk);
    b0.req_valid = 1'b0;
    check("mem0_2009", {24'b0, dut0.mem[32'h2009]}, 32'hAA);
    repeat (5) @(negedge clk);
    check("q2_drained", q2.size(), 32'd0);
    check("q0_drained", q0.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
